// File: rtl/glitcbus_pkg.sv
// Shared GLITCBUS definitions: FSM state encoding, marker bytes and
// protocol byte counts used by both bus endpoints.
package glitcbus_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ADDR    = 4'd1;
    localparam logic [3:0] ST_WDATA   = 4'd2;
    localparam logic [3:0] ST_WBUS    = 4'd3;
    localparam logic [3:0] ST_RTURN   = 4'd4;
    localparam logic [3:0] ST_RWAIT   = 4'd5;
    localparam logic [3:0] ST_RMARK   = 4'd6;
    localparam logic [3:0] ST_RDATA   = 4'd7;
    localparam logic [3:0] ST_RELEASE = 4'd8;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAC;
    localparam logic [7:0] ERR_BYTE_DEF  = 8'hEE;

    localparam int ADDR_BYTES = 2;
    localparam int DATA_BYTES = 4;

endpackage

// File: rtl/glitcbus_slave.sv
// GLITC-side GLITCBUS endpoint: turns select/strobe/GAD byte traffic into
// single 32-bit WISHBONE master cycles and returns read data framed by a marker.
//
// state   | meaning
// IDLE    | waiting for a falling edge on gsel_b_i (C0 latches rd/wr and addr high byte)
// ADDR    | remaining address byte(s)
// WDATA   | four write-data bytes, MSB first
// WBUS    | local write cycle open until ack/err/timeout
// RTURN   | bus turnaround, local read cycle already open
// RWAIT   | driving 8'h00 until ack/err/timeout
// RMARK   | driving SYNC_BYTE (good) or ERR_BYTE (err/timeout)
// RDATA   | four read-data bytes, MSB first
// RELEASE | bus released, waiting for gsel_b_i high
module glitcbus_slave
    import glitcbus_pkg::*;
#(
    parameter int          ADDR_BITS = 16,
    parameter int          TIMEOUT   = 16,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [7:0]  ERR_BYTE  = ERR_BYTE_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 gsel_b_i,
    input  logic                 grdwr_b_i,
    input  logic [7:0]           gad_i,
    output logic [7:0]           gad_o,
    output logic                 gad_oe_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [ADDR_BITS-1:0] adr_o,
    output logic [31:0]          dat_o,
    output logic [3:0]           sel_o,
    input  logic [31:0]          dat_i,
    input  logic                 ack_i,
    input  logic                 err_i,
    output logic                 busy_o
);

    logic [3:0]           state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [4:0]           tmo_q, tmo_d;
    logic                 sel_prev_q;
    logic                 rnw_q, rnw_d;
    logic                 good_q, good_d;
    logic [ADDR_BITS-1:0] adr_q, adr_d;
    logic [31:0]          wr_q, wr_d;
    logic [31:0]          rd_q, rd_d;
    logic                 expired;
    logic                 abortable;

    assign expired   = (tmo_q == 5'(TIMEOUT - 1));
    assign abortable = (state_q == ST_ADDR)  || (state_q == ST_WDATA) ||
                       (state_q == ST_RTURN) || (state_q == ST_RWAIT) ||
                       (state_q == ST_RMARK) || (state_q == ST_RDATA);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = 5'd0;
        rnw_d   = rnw_q;
        good_d  = good_q;
        adr_d   = adr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_prev_q && !gsel_b_i) begin
                    rnw_d   = grdwr_b_i;
                    adr_d   = {adr_q[ADDR_BITS-9:0], gad_i};
                    cnt_d   = 2'd1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                adr_d = {adr_q[ADDR_BITS-9:0], gad_i};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(ADDR_BYTES - 1)) begin
                    cnt_d   = 2'd0;
                    state_d = rnw_q ? ST_RTURN : ST_WDATA;
                end
            end
            ST_WDATA: begin
                wr_d  = {wr_q[23:0], gad_i};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(DATA_BYTES - 1))
                    state_d = ST_WBUS;
            end
            ST_WBUS: begin
                tmo_d = tmo_q + 5'd1;
                if (ack_i || err_i || expired)
                    state_d = ST_RELEASE;
            end
            ST_RTURN, ST_RWAIT: begin
                // a zero-wait slave may already answer during turnaround
                if (state_q == ST_RWAIT)
                    tmo_d = tmo_q + 5'd1;
                if (err_i || (state_q == ST_RWAIT && expired && !ack_i)) begin
                    rd_d    = 32'hFFFF_FFFF;
                    good_d  = 1'b0;
                    state_d = ST_RMARK;
                end else if (ack_i) begin
                    rd_d    = dat_i;
                    good_d  = 1'b1;
                    state_d = ST_RMARK;
                end else begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RMARK: begin
                cnt_d   = 2'd0;
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                rd_d  = {rd_q[23:0], 8'h00};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(DATA_BYTES - 1))
                    state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (gsel_b_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abortable && gsel_b_i)
            state_d = ST_IDLE;
    end

    // sel_prev_q resets low so a select held through reset is not an edge
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            tmo_q      <= 5'd0;
            sel_prev_q <= 1'b0;
            rnw_q      <= 1'b0;
            good_q     <= 1'b0;
            adr_q      <= '0;
            wr_q       <= 32'd0;
            rd_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            sel_prev_q <= gsel_b_i;
            rnw_q      <= rnw_d;
            good_q     <= good_d;
            adr_q      <= adr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_comb begin
        gad_o = 8'h00;
        case (state_q)
            ST_RMARK: gad_o = good_q ? SYNC_BYTE : ERR_BYTE;
            ST_RDATA: gad_o = rd_q[31:24];
            default:  gad_o = 8'h00;
        endcase
    end

    assign gad_oe_o = (state_q == ST_RWAIT) || (state_q == ST_RMARK) || (state_q == ST_RDATA);
    assign cyc_o    = (state_q == ST_WBUS) || (state_q == ST_RTURN) || (state_q == ST_RWAIT);
    assign stb_o    = cyc_o;
    assign we_o     = (state_q == ST_WBUS);
    assign adr_o    = adr_q;
    assign dat_o    = wr_q;
    assign sel_o    = 4'hF;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_glitcbus_slave.sv
// Scoreboard bench for glitcbus_slave: expected GAD bytes and local writes are
// queued as stimulus is driven and checked when the DUT produces them.
module tb_glitcbus_slave;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        gsel_b_i;
    logic        grdwr_b_i;
    logic [7:0]  gad_i;
    logic [7:0]  gad_o;
    logic        gad_oe_o;
    logic        cyc_o, stb_o, we_o;
    logic [15:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cycles = 0;
    int wr_seen = 0;
    int cyc_base;
    int wr_base;

    logic [7:0]  exp_bytes[$];
    logic [47:0] exp_wr[$];
    logic [7:0]  e_b;
    logic [47:0] e_w;

    glitcbus_slave dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .gsel_b_i  (gsel_b_i),
        .grdwr_b_i (grdwr_b_i),
        .gad_i     (gad_i),
        .gad_o     (gad_o),
        .gad_oe_o  (gad_oe_o),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .sel_o     (sel_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .err_i     (err_i),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // drives C0 and C1; returns with the DUT in C2
    task automatic start(input logic rnw, input logic [15:0] a);
        gsel_b_i  = 1'b0;
        grdwr_b_i = rnw;
        gad_i     = a[15:8];
        tick();
        grdwr_b_i = 1'b0;
        gad_i     = a[7:0];
        tick();
    endtask

    task automatic wr_bytes(input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            gad_i = d[31 - 8*i -: 8];
            tick();
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (cyc_o) cyc_cycles++;
            if (gad_oe_o) begin
                if (exp_bytes.size() == 0) begin
                    chk("gad_unexpected_oe", 64'(gad_oe_o), 64'd0);
                end else begin
                    e_b = exp_bytes.pop_front();
                    chk("gad_byte", 64'(gad_o), 64'(e_b));
                end
            end
            if (cyc_o && stb_o && we_o && (ack_i || err_i)) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 64'(we_o), 64'd0);
                end else begin
                    e_w = exp_wr.pop_front();
                    chk("wr_adr", 64'(adr_o), 64'(e_w[47:32]));
                    chk("wr_dat", 64'(dat_o), 64'(e_w[31:0]));
                    chk("wr_sel", 64'(sel_o), 64'hF);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b0; gsel_b_i = 1'b1; grdwr_b_i = 1'b0; gad_i = 8'h00;
        dat_i = 32'h0; ack_i = 1'b0; err_i = 1'b0;
        repeat (3) tick();
        chk("rst_cyc",  64'(cyc_o),    64'd0);
        chk("rst_stb",  64'(stb_o),    64'd0);
        chk("rst_we",   64'(we_o),     64'd0);
        chk("rst_oe",   64'(gad_oe_o), 64'd0);
        chk("rst_gad",  64'(gad_o),    64'd0);
        chk("rst_adr",  64'(adr_o),    64'd0);
        chk("rst_dat",  64'(dat_o),    64'd0);
        chk("rst_sel",  64'(sel_o),    64'hF);
        chk("rst_busy", 64'(busy_o),   64'd0);
        rst_i = 1'b1;
        tick();

        // write 0x1234 <= 0xDEADBEEF, ack two cycles after strobes rise
        wr_base = wr_seen;
        exp_wr.push_back({16'h1234, 32'hDEADBEEF});
        start(1'b0, 16'h1234);
        wr_bytes(32'hDEADBEEF);
        chk("wr_c6_cyc", 64'(cyc_o), 64'd1);
        chk("wr_c6_we",  64'(we_o),  64'd1);
        chk("wr_c6_adr", 64'(adr_o), 64'h1234);
        chk("wr_c6_dat", 64'(dat_o), 64'hDEADBEEF);
        chk("wr_c6_oe",  64'(gad_oe_o), 64'd0);
        tick();
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("wr_cyc_drop", 64'(cyc_o), 64'd0);
        chk("wr_count", 64'(wr_seen - wr_base), 64'd1);
        tick();
        tick();
        chk("wr_release_busy", 64'(busy_o), 64'd1);
        gsel_b_i = 1'b1;
        tick();
        chk("wr_idle", 64'(busy_o), 64'd0);

        // read, zero-wait ack in C2
        start(1'b1, 16'h0008);
        chk("rd0_adr", 64'(adr_o), 64'h0008);
        chk("rd0_turn_oe", 64'(gad_oe_o), 64'd0);
        chk("rd0_turn_cyc", 64'(cyc_o), 64'd1);
        chk("rd0_turn_we", 64'(we_o), 64'd0);
        dat_i = 32'hCAFEF00D;
        ack_i = 1'b1;
        exp_bytes.push_back(8'hAC);
        exp_bytes.push_back(8'hCA);
        exp_bytes.push_back(8'hFE);
        exp_bytes.push_back(8'hF0);
        exp_bytes.push_back(8'h0D);
        tick();
        ack_i = 1'b0;
        dat_i = 32'h0;
        chk("rd0_c3_cyc", 64'(cyc_o), 64'd0);
        repeat (5) tick();
        chk("rd0_c8_oe", 64'(gad_oe_o), 64'd0);
        chk("rd0_c8_busy", 64'(busy_o), 64'd1);
        gsel_b_i = 1'b1;
        tick();

        // read timeout: no ack ever
        start(1'b1, 16'h0010);
        for (int i = 0; i < 16; i++) exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'hEE);
        for (int i = 0; i < 4; i++) exp_bytes.push_back(8'hFF);
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 1)  chk("to_c3_oe",   64'(gad_oe_o), 64'd1);
            if (i == 16) chk("to_c18_cyc", 64'(cyc_o),    64'd1);
            if (i == 17) chk("to_c19_cyc", 64'(cyc_o),    64'd0);
        end
        chk("to_end_oe",   64'(gad_oe_o), 64'd0);
        chk("to_end_busy", 64'(busy_o),   64'd1);
        gsel_b_i = 1'b1;
        tick();

        // read with ack and err together in RWAIT: err wins
        start(1'b1, 16'h0020);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'hEE);
        for (int i = 0; i < 4; i++) exp_bytes.push_back(8'hFF);
        tick();
        tick();
        ack_i = 1'b1; err_i = 1'b1; dat_i = 32'h12345678;
        tick();
        ack_i = 1'b0; err_i = 1'b0; dat_i = 32'h0;
        repeat (5) tick();
        chk("ae_end_oe", 64'(gad_oe_o), 64'd0);
        gsel_b_i = 1'b1;
        tick();

        // abort after third write byte, then a fresh write two cycles later
        cyc_base = cyc_cycles;
        wr_base  = wr_seen;
        start(1'b0, 16'h5678);
        gad_i = 8'h11; tick();
        gad_i = 8'h22; tick();
        gad_i = 8'h33; tick();
        gsel_b_i = 1'b1;
        tick();
        chk("ab_busy", 64'(busy_o),   64'd0);
        chk("ab_cyc",  64'(cyc_o),    64'd0);
        chk("ab_oe",   64'(gad_oe_o), 64'd0);
        tick();
        chk("ab_no_cyc", 64'(cyc_cycles - cyc_base), 64'd0);
        exp_wr.push_back({16'h00AB, 32'h01020304});
        start(1'b0, 16'h00AB);
        wr_bytes(32'h01020304);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("ab_new_wr", 64'(wr_seen - wr_base), 64'd1);
        gsel_b_i = 1'b1;
        tick();

        // select held low through reset release
        rst_i = 1'b0; gsel_b_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        repeat (4) tick();
        chk("held_busy", 64'(busy_o), 64'd0);
        gsel_b_i = 1'b1;
        tick();
        chk("held_high_busy", 64'(busy_o), 64'd0);
        gsel_b_i = 1'b0;
        tick();
        chk("held_edge_busy", 64'(busy_o), 64'd1);
        gsel_b_i = 1'b1;
        tick();
        chk("held_abort_busy", 64'(busy_o), 64'd0);

        // reset while in RWAIT
        start(1'b1, 16'h0030);
        exp_bytes.push_back(8'h00);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("rrst_cyc",  64'(cyc_o),    64'd0);
        chk("rrst_oe",   64'(gad_oe_o), 64'd0);
        chk("rrst_busy", 64'(busy_o),   64'd0);
        rst_i = 1'b1;
        gsel_b_i = 1'b1;
        tick();
        tick();

        chk("bytes_left", 64'(exp_bytes.size()), 64'd0);
        chk("wr_left",    64'(exp_wr.size()),    64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
